// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receive path.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, RECV, PARITY, STOP} ps2_state_t;

  localparam logic [7:0]  PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS   = 11;

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// PS/2 line pair plus the decoded key event outputs.
interface ps2_scancode_decoder_if #(
  parameter int unsigned KEYCODE_WIDTH = 9
);
  logic                     PS2_CLK;
  logic                     PS2_DAT;
  logic [KEYCODE_WIDTH-1:0] keyCode;
  logic                     make;
  logic                     brake;

  // master: keyboard side and event consumer; slave: the decoder
  modport master (output PS2_CLK, PS2_DAT, input keyCode, make, brake);
  modport slave  (input PS2_CLK, PS2_DAT, output keyCode, make, brake);
endinterface

// File: rtl/ps2_input_sync.sv
// Synchronises raw PS/2 clock/data, glitch-filters the clock and emits a one-cycle
// strobe on each filtered falling edge together with the synchronised data.
module ps2_input_sync #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic strobe_o,
  output logic dat_o
);
  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]      clk_sync_q, dat_sync_q;
  logic            clk_filt_q, clk_filt_d;
  logic [CntW-1:0] filt_cnt_q, filt_cnt_d;
  logic            strobe_q, strobe_d;

  // The filtered clock only follows the synchronised clock once it has differed
  // for FILTER_LEN consecutive cycles; any shorter excursion restarts the count.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    strobe_d   = 1'b0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (filt_cnt_q == CntW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_sync_q[1];
        strobe_d   = clk_filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
      strobe_q   <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;
  assign dat_o    = dat_sync_q[1];

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 keyboard receiver: frame capture, E0/F0 prefix decode, make/brake events.
// Define PS2_PARITY_CHECK_EN to reject bytes with bad odd parity.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned KEYCODE_WIDTH  = 9,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                   clk,
  input logic                   resetN,
  ps2_scancode_decoder_if.slave bus
);
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

  logic strobe, dat_s;

  ps2_input_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync (
    .clk_i     (clk),
    .rst_ni    (resetN),
    .ps2_clk_i (bus.PS2_CLK),
    .ps2_dat_i (bus.PS2_DAT),
    .strobe_o  (strobe),
    .dat_o     (dat_s)
  );

  ps2_state_t              state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic [TimeoutW-1:0]     to_cnt_q, to_cnt_d;
  logic                    done_q, done_d;
  logic                    ok_q, ok_d;
  logic                    parity_ok;
  logic                    ext_q, brk_q;
  logic [KEYCODE_WIDTH-1:0] key_code_q;
  logic                    make_q, brake_q;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, parity_q};
`else
  logic unused_parity;
  assign parity_ok     = 1'b1;
  assign unused_parity = parity_q;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    to_cnt_d  = '0;
    done_d    = 1'b0;
    ok_d      = 1'b0;
    // A strobe always takes priority over an expiring timeout.
    if (strobe) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d   = RECV;
            bit_cnt_d = '0;
          end
        end
        RECV: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = dat_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          done_d  = 1'b1;
          ok_d    = dat_s & parity_ok;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_cnt_q == TimeoutW'(TIMEOUT_CYCLES)) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TimeoutW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
    end
  end

  // shift_q stays stable for the cycle after the stop strobe: the next strobe is
  // at least FILTER_LEN cycles away and is a start bit, which does not shift.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_code_q <= '0;
      make_q     <= 1'b0;
      brake_q    <= 1'b0;
    end else begin
      make_q  <= 1'b0;
      brake_q <= 1'b0;
      if (done_q) begin
        if (!ok_q) begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end else if (shift_q == PS2_EXT_PREFIX) begin
          ext_q <= 1'b1;
        end else if (shift_q == PS2_BREAK_PREFIX) begin
          brk_q <= 1'b1;
        end else begin
          key_code_q <= KEYCODE_WIDTH'({ext_q, shift_q});
          make_q     <= ~brk_q;
          brake_q    <= brk_q;
          ext_q      <= 1'b0;
          brk_q      <= 1'b0;
        end
      end
    end
  end

  assign bus.keyCode = key_code_q;
  assign bus.make    = make_q;
  assign bus.brake   = brake_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed frames plus random traffic
// checked every cycle against a byte-level decode model.
module tb_ps2_scancode_decoder;
  import ps2_pkg::*;

  localparam int unsigned Filt = 8;
  localparam int unsigned Tmo  = 2000;
  localparam int unsigned Half = 20;
`ifdef PS2_PARITY_CHECK_EN
  localparam logic [8:0] AfterBadPar = 9'h029;
  localparam int         BadParPulse = 0;
`else
  localparam logic [8:0] AfterBadPar = 9'h01C;
  localparam int         BadParPulse = 1;
`endif

  typedef struct {
    logic       brk;
    logic [8:0] code;
  } ev_t;

  logic        clk    = 1'b0;
  logic        resetN = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;

  logic        m_ext = 1'b0;
  logic        m_brk = 1'b0;
  logic [8:0]  m_code = '0;
  ev_t         exp_q[$];
  logic        last_brk = 1'b0;
  int          n_pulses = 0;

  ps2_scancode_decoder_if #(.KEYCODE_WIDTH(9)) bus ();

  ps2_scancode_decoder #(
    .KEYCODE_WIDTH  (9),
    .FILTER_LEN     (Filt),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Byte-level decode: prefixes set flags, other bytes emit an event, rejects clear flags.
  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back('{brk: m_brk, code: {m_ext, b}});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  // Compare process: every pulse must match the model queue, keyCode otherwise holds.
  initial begin
    ev_t ev;
    int  lat;
    forever begin
      @(negedge clk);
      if (resetN) begin
        chk("make_brake_exclusive", int'(bus.make & bus.brake), 0);
        if (bus.make || bus.brake) begin
          n_pulses++;
          last_brk = bus.brake;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got code 0x%0h make=%0b brake=%0b, required no pulse",
                     bus.keyCode, bus.make, bus.brake);
          end else begin
            ev = exp_q.pop_front();
            chk("pulse_code", int'(bus.keyCode), int'(ev.code));
            chk("pulse_is_brake", int'(bus.brake), int'(ev.brk));
            lat = int'(cyc - fall_cyc);
            checks++;
            if (lat < int'(Filt) + 2 || lat > int'(Filt) + 6) begin
              errors++;
              $display("FAIL pulse_latency: got %0d cycles after stop edge, required %0d..%0d",
                       lat, Filt + 2, Filt + 6);
            end
            m_code = ev.code;
          end
        end else if (exp_q.size() == 0) begin
          chk("keycode_hold", int'(bus.keyCode), int'(m_code));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    bus.PS2_DAT = b;
    if (glitch) begin
      wait_cyc(Half / 2);
      bus.PS2_CLK = 1'b0;
      wait_cyc(Filt - 3);
      bus.PS2_CLK = 1'b1;
      wait_cyc(Half / 2);
    end else begin
      wait_cyc(Half);
    end
    bus.PS2_CLK = 1'b0;
    fall_cyc = cyc;
    wait_cyc(Half);
    bus.PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_bit);
    logic [PS2_FRAME_BITS-1:0] f;
    bit ok;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
    ok = !bad_stop && !bad_par;
`else
    ok = !bad_stop;
`endif
    for (int i = 0; i < int'(PS2_FRAME_BITS); i++) begin
      if (i == int'(PS2_FRAME_BITS) - 1) model_byte(b, ok);
      ps2_bit(f[i], i == glitch_bit);
    end
    bus.PS2_DAT = 1'b1;
  endtask

  task automatic settle(input string name);
    wait_cyc(Half + 6);
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // pulse: 0 = none, 1 = make, 2 = brake
  task automatic frame_expect(input string name, input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int glitch_bit,
                              input logic [8:0] code, input int pulse);
    int n0;
    n0 = n_pulses;
    send_frame(b, bad_par, bad_stop, glitch_bit);
    settle(name);
    chk({name, "_code"}, int'(bus.keyCode), int'(code));
    chk({name, "_pulses"}, n_pulses - n0, (pulse != 0) ? 1 : 0);
    if (pulse != 0) chk({name, "_brake"}, int'(last_brk), (pulse == 2) ? 1 : 0);
  endtask

  task automatic partial_frame();
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 1'b0);
    bus.PS2_DAT = 1'b1;
  endtask

  initial begin
    logic [7:0] rb;
    int r;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    wait_cyc(3);
    chk("reset_keycode", int'(bus.keyCode), 0);
    chk("reset_make", int'(bus.make), 0);
    chk("reset_brake", int'(bus.brake), 0);
    resetN = 1'b1;
    wait_cyc(10);

    frame_expect("f_1c",      8'h1C, 1'b0, 1'b0, -1, 9'h01C, 1);
    frame_expect("f_f0",      8'hF0, 1'b0, 1'b0, -1, 9'h01C, 0);
    frame_expect("f_f0_1c",   8'h1C, 1'b0, 1'b0, -1, 9'h01C, 2);
    frame_expect("f_e0",      8'hE0, 1'b0, 1'b0, -1, 9'h01C, 0);
    frame_expect("f_e0_75",   8'h75, 1'b0, 1'b0, -1, 9'h175, 1);
    frame_expect("f_e0b",     8'hE0, 1'b0, 1'b0, -1, 9'h175, 0);
    frame_expect("f_e0_f0",   8'hF0, 1'b0, 1'b0, -1, 9'h175, 0);
    frame_expect("f_e0f0_75", 8'h75, 1'b0, 1'b0, -1, 9'h175, 2);
    frame_expect("f_29",      8'h29, 1'b0, 1'b0, -1, 9'h029, 1);
    frame_expect("f_badpar",  8'h1C, 1'b1, 1'b0, -1, AfterBadPar, BadParPulse);
    frame_expect("f_e0_c",    8'hE0, 1'b0, 1'b0, -1, AfterBadPar, 0);
    frame_expect("f_badstop", 8'h75, 1'b0, 1'b1, -1, AfterBadPar, 0);
    frame_expect("f_75_noext", 8'h75, 1'b0, 1'b0, -1, 9'h075, 1);

    // Lone clock pulse with data high must not start a frame.
    wait_cyc(Half);
    bus.PS2_CLK = 1'b0;
    wait_cyc(Half);
    bus.PS2_CLK = 1'b1;
    wait_cyc(Half);
    frame_expect("f_after_idle", 8'h1C, 1'b0, 1'b0, -1, 9'h01C, 1);

    frame_expect("f_glitch", 8'h5A, 1'b0, 1'b0, 3, 9'h05A, 1);

    // Stalled frame times out; a pending E0 survives the timeout.
    frame_expect("f_e0_to", 8'hE0, 1'b0, 1'b0, -1, 9'h05A, 0);
    r = n_pulses;
    partial_frame();
    wait_cyc(Tmo + 10);
    chk("timeout_no_pulse", n_pulses - r, 0);
    frame_expect("f_after_to", 8'h75, 1'b0, 1'b0, -1, 9'h175, 1);

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      rb = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      send_frame(rb, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, -1);
      settle("rand");
    end

    // Reset in the middle of a stalled frame clears everything immediately.
    send_frame(8'hE0, 1'b0, 1'b0, -1);
    settle("rst_e0");
    partial_frame();
    wait_cyc(Tmo / 2);
    resetN = 1'b0;
    #1;
    chk("midrst_keycode", int'(bus.keyCode), 0);
    chk("midrst_make", int'(bus.make), 0);
    chk("midrst_brake", int'(bus.brake), 0);
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_code = '0;
    exp_q.delete();
    wait_cyc(Tmo + 10);
    resetN = 1'b1;
    wait_cyc(10);
    frame_expect("f_after_rst", 8'h75, 1'b0, 1'b0, -1, 9'h075, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
